// File: rtl/dipsw_debounce.sv
// Multi-channel DIP switch synchronizer and debouncer feeding the switch PIO.
// Emits clean levels, rise/fall strobes, a settled flag and a saturating glitch counter.
module dipsw_debounce #(
  parameter int               WIDTH           = 2,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               CNT_W           = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic             glitch_clr,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             settled,
  output logic [7:0]       glitch_cnt
);

  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int               SETTLE_CYCLES = SYNC_STAGES + DEBOUNCE_CYCLES;
  localparam int               SET_W         = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SET_W-1:0] SETTLE_LAST   = SET_W'(SETTLE_CYCLES - 1);
  localparam int               ACC_W         = 9 + $clog2(WIDTH + 1);

  typedef enum logic {ST_STABLE, ST_PENDING} ch_state_t;

  logic [WIDTH-1:0] sync_reg [SYNC_STAGES];
  logic [WIDTH-1:0] sync_val;
  logic [WIDTH-1:0] sw_out_reg, sw_out_next;
  logic [WIDTH-1:0] rise_reg, rise_next;
  logic [WIDTH-1:0] fall_reg, fall_next;
  logic [WIDTH-1:0] glitch_vec;
  logic [7:0]       glitch_cnt_reg, glitch_cnt_next;
  logic [ACC_W-1:0] glitch_sum, glitch_total;
  logic [SET_W-1:0] settle_cnt_reg;
  logic             settled_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_reg[s] <= RESET_VALUE;
    end else begin
      sync_reg[0] <= sw_raw;
      for (int s = 1; s < SYNC_STAGES; s++) sync_reg[s] <= sync_reg[s-1];
    end
  end

  assign sync_val = sync_reg[SYNC_STAGES-1];

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_ch
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic             out_nx, rise_nx, fall_nx, glitch_nx;
      ch_state_t        state;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_reg <= '0;
        else          cnt_reg <= cnt_next;
      end

      // A non-zero counter means a candidate level is being timed.
      always_comb begin
        cnt_next  = cnt_reg;
        out_nx    = sw_out_reg[gi];
        rise_nx   = 1'b0;
        fall_nx   = 1'b0;
        glitch_nx = 1'b0;
        state     = (cnt_reg == '0) ? ST_STABLE : ST_PENDING;
        case (state)
          ST_STABLE: begin
            if (sync_val[gi] != sw_out_reg[gi]) cnt_next = CNT_W'(1);
          end
          ST_PENDING: begin
            if (sync_val[gi] == sw_out_reg[gi]) begin
              cnt_next  = '0;
              glitch_nx = 1'b1;
            end else if (cnt_reg == CNT_LAST) begin
              cnt_next = '0;
              out_nx   = sync_val[gi];
              rise_nx  = sync_val[gi];
              fall_nx  = ~sync_val[gi];
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end
          default: cnt_next = '0;
        endcase
      end

      assign sw_out_next[gi] = out_nx;
      assign rise_next[gi]   = rise_nx;
      assign fall_next[gi]   = fall_nx;
      assign glitch_vec[gi]  = glitch_nx;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_out_reg <= RESET_VALUE;
      rise_reg   <= '0;
      fall_reg   <= '0;
    end else begin
      sw_out_reg <= sw_out_next;
      rise_reg   <= rise_next;
      fall_reg   <= fall_next;
    end
  end

  // Clear wins over any glitch events arriving in the same cycle.
  always_comb begin
    glitch_sum = '0;
    for (int i = 0; i < WIDTH; i++) glitch_sum = glitch_sum + ACC_W'(glitch_vec[i]);
    glitch_total = ACC_W'(glitch_cnt_reg) + glitch_sum;
    if (glitch_clr)                       glitch_cnt_next = 8'd0;
    else if (glitch_total > ACC_W'(255))  glitch_cnt_next = 8'hFF;
    else                                  glitch_cnt_next = glitch_total[7:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) glitch_cnt_reg <= 8'd0;
    else          glitch_cnt_reg <= glitch_cnt_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      settle_cnt_reg <= '0;
      settled_reg    <= 1'b0;
    end else if (!settled_reg) begin
      if (settle_cnt_reg == SETTLE_LAST) settled_reg <= 1'b1;
      else                               settle_cnt_reg <= settle_cnt_reg + SET_W'(1);
    end
  end

  assign sw_out     = sw_out_reg;
  assign sw_rise    = rise_reg;
  assign sw_fall    = fall_reg;
  assign settled    = settled_reg;
  assign glitch_cnt = glitch_cnt_reg;

endmodule

// File: tb/tb_dipsw_debounce.sv
// Scoreboard bench for dipsw_debounce: a sliding-window reference model predicts each
// cycle's outputs, a monitor compares them one cycle at a time.
module tb_dipsw_debounce;

  localparam int             W  = 2;
  localparam int             SS = 2;
  localparam int             D  = 8;
  localparam int             CW = 4;
  localparam logic [W-1:0]   RV = 2'b00;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] sw_raw = '0;
  logic         glitch_clr = 1'b0;
  logic [W-1:0] sw_out, sw_rise, sw_fall;
  logic         settled;
  logic [7:0]   glitch_cnt;

  dipsw_debounce #(
    .WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(D), .CNT_W(CW), .RESET_VALUE(RV)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sw_raw(sw_raw), .glitch_clr(glitch_clr),
    .sw_out(sw_out), .sw_rise(sw_rise), .sw_fall(sw_fall),
    .settled(settled), .glitch_cnt(glitch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] out;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         settled;
    logic [7:0]   g;
  } exp_t;

  exp_t scb[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: the FSM sees the raw level SS edges late; a level is accepted once
  // the last D observed samples all differ from the current output.
  logic [W-1:0] m_syncq[$];
  logic [W-1:0] m_win[D];
  logic [W-1:0] m_out, m_rise, m_fall;
  int           m_g, m_edges;

  function automatic void model_reset();
    m_syncq.delete();
    for (int k = 0; k < SS; k++) m_syncq.push_back(RV);
    for (int k = 0; k < D; k++) m_win[k] = RV;
    m_out = RV; m_rise = '0; m_fall = '0; m_g = 0; m_edges = 0;
  endfunction

  function automatic void model_edge(input logic [W-1:0] raw, input logic clr);
    logic [W-1:0] s, prev;
    int n;
    bit all_diff;
    s = m_syncq.pop_front();
    m_syncq.push_back(raw);
    prev = m_win[D-1];
    for (int j = 0; j < D-1; j++) m_win[j] = m_win[j+1];
    m_win[D-1] = s;
    m_rise = '0; m_fall = '0; n = 0;
    for (int i = 0; i < W; i++) begin
      if (s[i] == m_out[i]) begin
        if (prev[i] != m_out[i]) n++;
      end else begin
        all_diff = 1'b1;
        for (int j = 0; j < D; j++) if (m_win[j][i] == m_out[i]) all_diff = 1'b0;
        if (all_diff) begin
          m_out[i] = s[i];
          if (s[i]) m_rise[i] = 1'b1; else m_fall[i] = 1'b1;
        end
      end
    end
    m_g = clr ? 0 : ((m_g + n > 255) ? 255 : m_g + n);
    m_edges++;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: got %0h required %0h", name, $time, act, req);
    end
  endfunction

  task automatic step(input logic [W-1:0] raw, input logic clr, input logic rst_n);
    exp_t e;
    @(negedge clk);
    sw_raw = raw; glitch_clr = clr;
    if (!rst_n) begin
      reset_n = 1'b0;
      model_reset();
      #1;
      chk("reset_async_out", 32'(sw_out), 32'(RV));
    end else begin
      reset_n = 1'b1;
      model_edge(raw, clr);
    end
    e.out = m_out; e.rise = m_rise; e.fall = m_fall;
    e.settled = (m_edges >= SS + D); e.g = 8'(m_g);
    scb.push_back(e);
  endtask

  task automatic hold(input logic [W-1:0] raw, input int n, input logic clr);
    for (int k = 0; k < n; k++) step(raw, clr, 1'b1);
  endtask

  // Monitor: every cycle the DUT presents a full output set.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (scb.size() > 0) begin
      e = scb.pop_front();
      chk("sw_out", 32'(sw_out), 32'(e.out));
      chk("sw_rise", 32'(sw_rise), 32'(e.rise));
      chk("sw_fall", 32'(sw_fall), 32'(e.fall));
      chk("settled", 32'(settled), 32'(e.settled));
      chk("glitch_cnt", 32'(glitch_cnt), 32'(e.g));
      if ((e.rise | e.fall) != '0)
        $display("edge t=%0t sw_out=%b rise=%b fall=%b glitch_cnt=%0d", $time, sw_out, sw_rise, sw_fall, glitch_cnt);
    end
  end

  initial begin
    logic [W-1:0] cur;
    int           mode;
    model_reset();
    // reset, then idle through the settle window
    for (int k = 0; k < 3; k++) step(2'b00, 1'b0, 1'b0);
    hold(2'b00, 12, 1'b0);
    // clean step on channel 0
    hold(2'b01, 14, 1'b0);
    // short pulse on channel 1
    hold(2'b11, 5, 1'b0);
    hold(2'b01, 6, 1'b0);
    // bounce on channel 0, then settle low
    hold(2'b00, 2, 1'b0); hold(2'b01, 2, 1'b0);
    hold(2'b00, 2, 1'b0); hold(2'b01, 2, 1'b0);
    hold(2'b00, 14, 1'b0);
    // window boundaries: D-1 cycles rejected, D cycles accepted
    hold(2'b01, D-1, 1'b0); hold(2'b00, 10, 1'b0);
    hold(2'b01, D, 1'b0);   hold(2'b00, 14, 1'b0);
    // dual glitch under clear
    hold(2'b11, 3, 1'b1); hold(2'b00, 4, 1'b1);
    // saturation
    for (int k = 0; k < 200; k++) begin
      hold(2'b11, 3, 1'b0); hold(2'b00, 3, 1'b0);
    end
    hold(2'b00, 2, 1'b1);
    // reset mid-window, then accept after release
    hold(2'b01, 7, 1'b0);
    for (int k = 0; k < 3; k++) step(2'b01, 1'b0, 1'b0);
    hold(2'b01, 14, 1'b0);
    // randomized activity
    cur = 2'b01;
    mode = 0;
    for (int k = 0; k < 3000; k++) begin
      if (k % 200 == 0) mode = $urandom_range(0, 1);
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, mode ? 14 : 3) == 0) cur[i] = ~cur[i];
      if ($urandom_range(0, 599) == 0) begin
        step(cur, 1'b0, 1'b0);
        step(cur, 1'b0, 1'b0);
      end else begin
        step(cur, ($urandom_range(0, 49) == 0), 1'b1);
      end
    end
    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(scb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
